ppg_afe_model: RTL and testbench
================================

# ppg_afe_model

Synthesizable model of the pulse-oximeter analog front end: photodiode, DC-compensation DAC, PGA and 8-bit ADC. It sits on the other side of the controller interface. It consumes LED_RED/LED_IR, DC_Comp, PGA_Gain and CLK_Filter, and returns the ADC code the controller calibrates against. It generates a triangular heartbeat waveform so that closed-loop DC/PGA calibration and LED switching can be exercised in simulation and on FPGA.

## Interface
- RED_DC, 400: red photodiode DC level (10-bit scale)
- IR_DC, 300: IR photodiode DC level
- RED_AC, 20: red pulsatile amplitude (0..255)
- IR_AC, 30: IR pulsatile amplitude
- DARK, 16: photodiode level with both LEDs off
- DC_STEP, 4: photodiode units per DC_Comp LSB
- STEP_DIV, 8: CLK cycles per triangle step
- SETTLE, 3: CLK cycles of sample blanking after any LED change
- CLK  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- LED_RED  in  1  red LED enable
- LED_IR  in  1  IR LED enable
- DC_Comp  in  7  DC compensation code
- PGA_Gain  in  4  PGA setting; linear gain G = PGA_Gain+1
- CLK_Filter  in  1  filter/ADC sample clock; sampled synchronously on CLK
- ADC  out  8  converted code
- ADC_valid  out  1  one-cycle pulse when ADC updates

## Operation
- Triangle generator:
  - 6-bit tri counts 0→63→0 with an up/down direction flag.
  - One step per STEP_DIV CLK cycles, using a prescaler counter.
  - Full period is 126·STEP_DIV cycles. The direction flips on reaching 63 and on reaching 0; 63 and 0 each appear for exactly one step.
- Waveform per LED: wave_X = (tri·X_AC)>>6, unsigned.
- Photodiode p (unsigned 11-bit):
  - RED only: RED_DC+wave_red.
  - IR only: IR_DC+wave_ir.
  - Both on: the sum of both.
  - Both off: DARK.
- LED-change detect: led_prev register holds {LED_RED,LED_IR}. Any difference loads settle_cnt=SETTLE; settle_cnt otherwise decrements to 0 and holds.
- Filter edge detect: filt_prev register. A rising edge means CLK_Filter=1 and filt_prev=0.
- Stage 1:
  - Fires on a filter rising edge with settle_cnt==0 and no LED change this cycle.
  - Registers diff = p − DC_Comp·DC_STEP as signed 12-bit.
- Stage 2, the CLK after stage 1 fires:
  - amp = (diff·G)>>>2, arithmetic, signed 17-bit.
  - code = 128+amp, clamped to [0,255].
  - Register ADC=code and pulse ADC_valid.
- ADC holds its value between samples and during settle blanking.
- DC_Comp/PGA_Gain: DC_Comp is used at stage 1 and PGA_Gain at stage 2. Mid-pipeline changes are not rejected.

## Timing
- Reset values: ADC=0, ADC_valid=0, tri=0, direction=up, prescaler=0, settle_cnt=0, led_prev=0, filt_prev=0, stage registers 0.
- Latency: filter rising edge → ADC/ADC_valid 1 CLK later. The edge is detected the CLK after CLK_Filter rises.
- Max sample rate: one per 2 CLK, matching a CLK_Filter that toggles every CLK.
- Simultaneous LED change and filter edge: the change wins and no sample is taken.
- First sample after a change: not before change+SETTLE+1 cycles.
- Reset asserted mid-pipeline: an in-flight stage-1 result is discarded, and no ADC_valid is issued after release until a new edge.
- Clamp boundaries: amp ≥ 128 → 255; amp ≤ −128 → 0.

## Test plan
- RED only, DC_Comp=100, PGA_Gain=0, tri frozen at 0 (STEP_DIV large) → ADC=128. At tri=63 → wave 19, ADC=132.
- RED only, DC_Comp=127, PGA_Gain=0 → diff −108, ADC=101. With PGA_Gain=15 → −432, ADC clamps to 0.
- Both off, DC_Comp=0, PGA_Gain=15 → diff 16, amp 64, ADC=192. Both on, DC_Comp=127, G=1 → diff 192, ADC=176 at tri=0.
- Toggle LED_RED→LED_IR with CLK_Filter toggling every CLK → no ADC_valid for SETTLE+1 cycles, then IR codes appear. Check with IR-only DC_Comp=75: diff 0, ADC=128 at tri=0.
- Triangle: STEP_DIV=1 → tri hits 63 at cycle 63 and returns to 0 at cycle 126; waveform period is 126 cycles.
- Assert rst_n low for 1 cycle between a filter edge and stage 2 → ADC=0, no ADC_valid; normal sampling resumes on the next edge.

Source files
------------

// File: rtl/ppg_afe_model.sv
// Pulse-oximeter analog front end model: photodiode with triangular heartbeat,
// DC-compensation DAC, PGA and 8-bit ADC sampled on rising edges of CLK_Filter.
`timescale 1ns/1ps
module ppg_afe_model #(
  parameter int RED_DC   = 400,
  parameter int IR_DC    = 300,
  parameter int RED_AC   = 20,
  parameter int IR_AC    = 30,
  parameter int DARK     = 16,
  parameter int DC_STEP  = 4,
  parameter int STEP_DIV = 8,
  parameter int SETTLE   = 3
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       LED_RED,
  input  logic       LED_IR,
  input  logic [6:0] DC_Comp,
  input  logic [3:0] PGA_Gain,
  input  logic       CLK_Filter,
  output logic [7:0] ADC,
  output logic       ADC_valid
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(STEP_DIV - 1);
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE);

  logic [PRE_W-1:0] pre_cnt;
  logic [5:0]       tri_cnt;
  dir_e             dir;

  // The direction flips as the count arrives at an end, so 63 and 0 each last one step.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      tri_cnt <= '0;
      dir     <= DIR_UP;
    end else if (pre_cnt == PRE_MAX) begin
      pre_cnt <= '0;
      if (dir == DIR_UP) begin
        tri_cnt <= tri_cnt + 6'd1;
        if (tri_cnt == 6'd62) dir <= DIR_DOWN;
      end else begin
        tri_cnt <= tri_cnt - 6'd1;
        if (tri_cnt == 6'd1) dir <= DIR_UP;
      end
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  logic [7:0]  wave_red, wave_ir;
  logic [10:0] pd;

  assign wave_red = 8'((14'(tri_cnt) * 14'(RED_AC)) >> 6);
  assign wave_ir  = 8'((14'(tri_cnt) * 14'(IR_AC)) >> 6);

  // NOTE: a default assignment first keeps this combinational block latch-free.
  always_comb begin
    pd = 11'(DARK);
    case ({LED_RED, LED_IR})
      2'b10:   pd = 11'(RED_DC) + 11'(wave_red);
      2'b01:   pd = 11'(IR_DC) + 11'(wave_ir);
      2'b11:   pd = 11'(RED_DC) + 11'(wave_red) + 11'(IR_DC) + 11'(wave_ir);
      default: pd = 11'(DARK);
    endcase
  end

  logic [1:0]        led_prev;
  logic              filt_prev;
  logic [SET_W-1:0]  settle_cnt;
  logic              led_change, filt_rise, s1_fire, s1_valid;
  logic signed [11:0] diff_next, diff_q;

  assign led_change = ({LED_RED, LED_IR} != led_prev);
  assign filt_rise  = CLK_Filter & ~filt_prev;
  // An LED change on the same cycle as a filter edge suppresses the sample.
  assign s1_fire    = filt_rise && (settle_cnt == '0) && !led_change;
  assign diff_next  = $signed(12'(pd) - 12'(DC_Comp) * 12'(DC_STEP));

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      led_prev   <= '0;
      filt_prev  <= 1'b0;
      settle_cnt <= '0;
      s1_valid   <= 1'b0;
      diff_q     <= '0;
    end else begin
      led_prev  <= {LED_RED, LED_IR};
      filt_prev <= CLK_Filter;
      if (led_change)             settle_cnt <= SET_LOAD;
      else if (settle_cnt != '0)  settle_cnt <= settle_cnt - SET_W'(1);
      s1_valid <= s1_fire;
      if (s1_fire) diff_q <= diff_next;
    end
  end

  logic signed [5:0]  gain;
  logic signed [17:0] prod;
  logic signed [16:0] amp;
  logic [7:0]         code;

  assign gain = $signed({1'b0, 5'(PGA_Gain) + 5'd1});
  assign prod = 18'(diff_q) * 18'(gain);
  assign amp  = 17'(prod >>> 2);

  always_comb begin
    code = 8'd0;
    if (amp >= 17'sd128)       code = 8'd255;
    else if (amp <= -17'sd128) code = 8'd0;
    else                       code = 8'(amp + 17'sd128);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ADC       <= 8'd0;
      ADC_valid <= 1'b0;
    end else begin
      ADC_valid <= s1_valid;
      if (s1_valid) ADC <= code;
    end
  end

endmodule

// File: tb/tb_ppg_afe_model.sv
// Directed bench for ppg_afe_model: one instance with a slow triangle for
// level/settle/pipeline scenarios, one with a fast, high-gain triangle for shape.
`timescale 1ns/1ps
module tb_ppg_afe_model;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, led_red, led_ir, clk_filter;
  logic [6:0] dc_comp;
  logic [3:0] pga_gain;
  logic [7:0] adc;
  logic       adc_valid;

  logic       rst2_n, led_red2, led_ir2, filt2;
  logic [6:0] dc2;
  logic [3:0] gain2;
  logic [7:0] adc2;
  logic       valid2;

  int passed = 0;
  int total  = 0;

  ppg_afe_model #(.STEP_DIV(256)) dut (
    .CLK(clk), .rst_n(rst_n), .LED_RED(led_red), .LED_IR(led_ir),
    .DC_Comp(dc_comp), .PGA_Gain(pga_gain), .CLK_Filter(clk_filter),
    .ADC(adc), .ADC_valid(adc_valid)
  );

  // Code equals the raw red waveform here: p - 128 at gain 4 maps back onto 0..255.
  ppg_afe_model #(.RED_DC(0), .RED_AC(255), .STEP_DIV(1)) dut_tri (
    .CLK(clk), .rst_n(rst2_n), .LED_RED(led_red2), .LED_IR(led_ir2),
    .DC_Comp(dc2), .PGA_Gain(gain2), .CLK_Filter(filt2),
    .ADC(adc2), .ADC_valid(valid2)
  );

  function automatic int tri_at(input int n);
    int m;
    m = n % 126;
    return (m <= 63) ? m : 126 - m;
  endfunction

  task automatic reset_dut(input logic r, input logic i, input logic [6:0] dc, input logic [3:0] g);
    @(negedge clk);
    rst_n = 1'b0; clk_filter = 1'b0;
    led_red = r; led_ir = i; dc_comp = dc; pga_gain = g;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Called at a negedge with clk_filter low; returns the outputs after stage 2.
  task automatic take_sample(output logic [7:0] code, output logic v);
    clk_filter = 1'b1;
    @(negedge clk);
    clk_filter = 1'b0;
    @(negedge clk);
    code = adc;
    v    = adc_valid;
  endtask

  task automatic test_reset();
    #1;
    total++; if (adc !== 8'd0)  $display("FAIL reset_adc got %0d want 0", adc);  else passed++;
    total++; if (adc_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", adc_valid); else passed++;
    total++; if (adc2 !== 8'd0) $display("FAIL reset_adc2 got %0d want 0", adc2); else passed++;
    total++; if (valid2 !== 1'b0) $display("FAIL reset_valid2 got %b want 0", valid2); else passed++;
  endtask

  task automatic test_red_only();
    logic [7:0] c; logic v;
    reset_dut(1'b1, 1'b0, 7'd100, 4'd0);
    take_sample(c, v);
    total++; if (c !== 8'd128 || v !== 1'b1) $display("FAIL red_dc100 got %0d/%b want 128/1", c, v); else passed++;
    dc_comp = 7'd127;
    take_sample(c, v);
    total++; if (c !== 8'd101 || v !== 1'b1) $display("FAIL red_dc127 got %0d/%b want 101/1", c, v); else passed++;
    repeat (4) @(negedge clk);
    total++; if (adc !== 8'd101 || adc_valid !== 1'b0) $display("FAIL hold got %0d/%b want 101/0", adc, adc_valid); else passed++;
    pga_gain = 4'd15;
    take_sample(c, v);
    total++; if (c !== 8'd0 || v !== 1'b1) $display("FAIL red_clamp_low got %0d/%b want 0/1", c, v); else passed++;
  endtask

  task automatic test_dark_both();
    logic [7:0] c; logic v;
    reset_dut(1'b0, 1'b0, 7'd0, 4'd15);
    take_sample(c, v);
    total++; if (c !== 8'd192 || v !== 1'b1) $display("FAIL dark got %0d/%b want 192/1", c, v); else passed++;
    led_red = 1'b1; led_ir = 1'b1; dc_comp = 7'd127; pga_gain = 4'd0;
    repeat (5) @(negedge clk);
    take_sample(c, v);
    total++; if (c !== 8'd176 || v !== 1'b1) $display("FAIL both_on got %0d/%b want 176/1", c, v); else passed++;
  endtask

  task automatic test_led_switch();
    logic [7:0] c; logic v;
    int first, nvalid, bad;
    reset_dut(1'b1, 1'b0, 7'd75, 4'd0);
    take_sample(c, v);
    total++; if (c !== 8'd153 || v !== 1'b1) $display("FAIL red_dc75 got %0d/%b want 153/1", c, v); else passed++;
    // LED change and filter rising edge land on the same clock.
    led_red = 1'b0; led_ir = 1'b1; clk_filter = 1'b1;
    first = -1; nvalid = 0; bad = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (adc_valid) begin
        if (first < 0) first = j;
        nvalid++;
        if (adc !== 8'd128) bad++;
      end
      clk_filter = ~clk_filter;
    end
    clk_filter = 1'b0;
    @(negedge clk);
    total++; if (first !== 5) $display("FAIL settle_first_valid got %0d want 5", first); else passed++;
    total++; if (nvalid !== 6) $display("FAIL settle_valid_count got %0d want 6", nvalid); else passed++;
    total++; if (bad !== 0) $display("FAIL ir_codes got %0d wrong want 0 wrong", bad); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [6:0] dcs [3];
    logic [7:0] codes [3];
    dcs   = '{7'd100, 7'd127, 7'd90};
    codes = '{8'd128, 8'd101, 8'd138};
    reset_dut(1'b1, 1'b0, 7'd100, 4'd0);
    for (int k = 0; k < 3; k++) begin
      clk_filter = 1'b1; dc_comp = dcs[k];
      @(negedge clk);
      clk_filter = 1'b0;
      if (k > 0) begin
        total++;
        if (adc_valid !== 1'b0 || adc !== codes[k-1])
          $display("FAIL b2b_gap%0d got %0d/%b want %0d/0", k, adc, adc_valid, codes[k-1]);
        else passed++;
      end
      @(negedge clk);
      total++;
      if (adc_valid !== 1'b1 || adc !== codes[k])
        $display("FAIL b2b_sample%0d got %0d/%b want %0d/1", k, adc, adc_valid, codes[k]);
      else passed++;
    end
  endtask

  task automatic test_pipeline_reset();
    logic [7:0] c; logic v;
    int nvalid;
    reset_dut(1'b1, 1'b0, 7'd100, 4'd0);
    take_sample(c, v);
    total++; if (c !== 8'd128 || v !== 1'b1) $display("FAIL prereset got %0d/%b want 128/1", c, v); else passed++;
    dc_comp = 7'd127;
    clk_filter = 1'b1;
    @(negedge clk);
    rst_n = 1'b0; clk_filter = 1'b0;
    #1;
    total++; if (adc !== 8'd0 || adc_valid !== 1'b0) $display("FAIL midreset got %0d/%b want 0/0", adc, adc_valid); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (adc_valid) nvalid++;
    end
    total++; if (nvalid !== 0 || adc !== 8'd0) $display("FAIL postreset got %0d valids adc %0d want 0 valids adc 0", nvalid, adc); else passed++;
    repeat (4) @(negedge clk);
    take_sample(c, v);
    total++; if (c !== 8'd101 || v !== 1'b1) $display("FAIL resume got %0d/%b want 101/1", c, v); else passed++;
  endtask

  task automatic test_tri_peak();
    logic [7:0] c; logic v;
    reset_dut(1'b1, 1'b0, 7'd100, 4'd0);
    repeat (16200) @(negedge clk);
    take_sample(c, v);
    total++; if (c !== 8'd132 || v !== 1'b1) $display("FAIL tri63_red got %0d/%b want 132/1", c, v); else passed++;
  endtask

  // Stage 1 fires on edge n+1 and so sees the triangle after n steps.
  task automatic tri_point(input int n);
    logic [7:0] expv;
    expv = 8'((tri_at(n) * 255) >> 6);
    @(negedge clk);
    rst2_n = 1'b0; filt2 = 1'b0; led_red2 = 1'b1;
    @(negedge clk);
    rst2_n = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    filt2 = 1'b1;
    @(negedge clk);
    filt2 = 1'b0;
    @(negedge clk);
    total++;
    if (valid2 !== 1'b1 || adc2 !== expv)
      $display("FAIL tri_cycle%0d got %0d/%b want %0d/1", n, adc2, valid2, expv);
    else passed++;
  endtask

  task automatic test_triangle();
    tri_point(62);
    tri_point(63);
    tri_point(64);
    tri_point(125);
    tri_point(126);
    tri_point(127);
    tri_point(189);
  endtask

  initial begin
    rst_n = 1'b0; led_red = 1'b0; led_ir = 1'b0; clk_filter = 1'b0;
    dc_comp = 7'd0; pga_gain = 4'd0;
    rst2_n = 1'b0; led_red2 = 1'b0; led_ir2 = 1'b0; filt2 = 1'b0;
    dc2 = 7'd32; gain2 = 4'd3;
    test_reset();
    test_red_only();
    test_dark_both();
    test_led_switch();
    test_back_to_back();
    test_pipeline_reset();
    test_tri_peak();
    test_triangle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
